// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters.
// One access in flight at a time; reads complete after a fixed READ_LATENCY.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state, state_n;
    logic                  last_gnt, last_gnt_n;
    logic                  sel, sel_n;
    logic                  cur_we, cur_we_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  win;

    logic                  r0_gnt_n, r0_rvalid_n, r1_gnt_n, r1_rvalid_n;
    logic [DATA_WIDTH-1:0] r0_rdata_n, r1_rdata_n;
    logic                  mem_we_n, busy_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_data_n;

    // Both requesting: the port that did not win last time goes first.
    assign win = (r0_req && r1_req) ? ~last_gnt : r1_req;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n     = state;
        last_gnt_n  = last_gnt;
        sel_n       = sel;
        cur_we_n    = cur_we;
        cnt_n       = cnt;
        r0_gnt_n    = 1'b0;
        r1_gnt_n    = 1'b0;
        r0_rvalid_n = 1'b0;
        r1_rvalid_n = 1'b0;
        r0_rdata_n  = r0_rdata;
        r1_rdata_n  = r1_rdata;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_data_n  = mem_data;

        unique case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    sel_n      = win;
                    last_gnt_n = win;
                    cur_we_n   = win ? r1_we : r0_we;
                    mem_we_n   = win ? r1_we : r0_we;
                    mem_addr_n = win ? r1_addr : r0_addr;
                    mem_data_n = win ? r1_wdata : r0_wdata;
                    r0_gnt_n   = ~win;
                    r1_gnt_n   = win;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_we) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = CNT_W'(READ_LATENCY - 1);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    if (sel) begin
                        r1_rdata_n  = mem_q;
                        r1_rvalid_n = 1'b1;
                    end else begin
                        r0_rdata_n  = mem_q;
                        r0_rvalid_n = 1'b1;
                    end
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            sel       <= 1'b0;
            cur_we    <= 1'b0;
            cnt       <= '0;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            last_gnt  <= last_gnt_n;
            sel       <= sel_n;
            cur_we    <= cur_we_n;
            cnt       <= cnt_n;
            r0_gnt    <= r0_gnt_n;
            r1_gnt    <= r1_gnt_n;
            r0_rvalid <= r0_rvalid_n;
            r1_rvalid <= r1_rvalid_n;
            r0_rdata  <= r0_rdata_n;
            r1_rdata  <= r1_rdata_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_data  <= mem_data_n;
            busy      <= busy_n;
        end
    end

endmodule
